// File: rtl/ram_bank.sv
// ram_bank: single-port word RAM with a power-on clear sequence and a
// registered 1-cycle read port.
//
// After reset_n releases, the bank walks every address writing zero (busy=1)
// and then accepts load/rd commands. Memory itself has no reset; only the
// clear walk zeroes it.
//
// Build option: define RAM_BANK_WRFWD_EN for write-first forwarding on a
// simultaneous load+rd (the new data is returned). Without it the read
// returns the old contents and the write still lands.
module ram_bank #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] adr,
  input  logic [WIDTH-1:0]  data,
  input  logic              load,
  input  logic              rd,
  output logic [WIDTH-1:0]  out,
  output logic              out_valid,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    StClear = 1'b0,
    StReady = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic                out_valid_q, out_valid_d;

  logic [WIDTH-1:0]    mem [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [WIDTH-1:0]    mem_wd;
  logic [WIDTH-1:0]    rd_data;
  logic                clr_last;

  // The pointer reaching all-ones is the write of address DEPTH-1.
  assign clr_last = &clr_ptr_q;

`ifdef RAM_BANK_WRFWD_EN
  // Same-cycle load+rd always targets the same word: forward the new data.
  assign rd_data = load ? data : mem[adr];
`else
  // Read-first: the array read sees the contents before this edge's write.
  assign rd_data = mem[adr];
`endif

  // Next-state, clear pointer and read register decode.
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      StClear: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_last) begin
          state_d = StReady;
        end
      end
      StReady: begin
        if (rd) begin
          out_d       = rd_data;
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = StClear;
      end
    endcase
  end

  // Memory write port select: clear walk owns the array while busy.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = adr;
    mem_wd = data;
    if (state_q == StClear) begin
      mem_we = 1'b1;
      mem_wa = clr_ptr_q;
      mem_wd = '0;
    end else if (load) begin
      mem_we = 1'b1;
    end
    // Writes coinciding with reset are dropped.
    if (!reset_n) begin
      mem_we = 1'b0;
    end
  end

  // Control and read-data registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StClear;
      clr_ptr_q   <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  // Pure state decode: no input reaches busy combinationally.
  assign busy      = (state_q == StClear);

endmodule
